// File: rtl/spi_cmd_if.sv
// SPI mode-0 slave front-end: decodes 16-bit command/data frames into module
// register strobes (ioc, data, one-hot select, fetch/load) and returns read data on MISO.
module spi_cmd_if (
  input  logic        i_sys_clk,
  input  logic        i_rst_b,
  input  logic        i_spi_sck,
  input  logic        i_spi_mosi,
  input  logic        i_spi_cs_n,
  output logic        o_spi_miso,
  output logic [4:0]  o_ioc,
  output logic [7:0]  o_data_in,
  output logic [3:0]  o_cs_vec,
  output logic        o_fetch_cmd,
  output logic        o_load_cmd,
  input  logic [31:0] i_rd_data
);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_e;

  // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
  logic [2:0] sck_q, csn_q;
  logic [1:0] mosi_q;
  logic [1:0] vld_q;
  logic       armed_q, armed_d;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       dir_q, dir_d;
  logic [1:0] mod_q, mod_d;
  logic [4:0] ioc_q, ioc_d;
  logic [7:0] data_q, data_d;
  logic [3:0] cs_vec_q, cs_vec_d;
  logic       fetch_q, fetch_d;
  logic       fetch_dly_q;
  logic       load_q, load_d;
  logic [7:0] tx_q, tx_d;

  logic       sck_rise, sck_fall, cs_rise, cs_fall;
  logic [7:0] new_byte;
  logic [7:0] rd_byte;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = csn_q[1] & ~csn_q[2];
  assign cs_fall  = ~csn_q[1] & csn_q[2];
  assign new_byte = {shift_q[6:0], mosi_q[1]};
  assign rd_byte  = i_rd_data[{mod_q, 3'b000} +: 8];

  // Only arm once cs_n has been seen high through a flushed synchronizer, so a
  // frame already in progress at reset release is ignored.
  assign armed_d = armed_q | (vld_q[1] & csn_q[1]);

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      sck_q   <= 3'b000;
      mosi_q  <= 2'b00;
      csn_q   <= 3'b111;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sck_q   <= {sck_q[1:0], i_spi_sck};
      mosi_q  <= {mosi_q[0], i_spi_mosi};
      csn_q   <= {csn_q[1:0], i_spi_cs_n};
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      shift_q     <= 8'd0;
      dir_q       <= 1'b0;
      mod_q       <= 2'd0;
      ioc_q       <= 5'd0;
      data_q      <= 8'd0;
      cs_vec_q    <= 4'd0;
      fetch_q     <= 1'b0;
      fetch_dly_q <= 1'b0;
      load_q      <= 1'b0;
      tx_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      dir_q       <= dir_d;
      mod_q       <= mod_d;
      ioc_q       <= ioc_d;
      data_q      <= data_d;
      cs_vec_q    <= cs_vec_d;
      fetch_q     <= fetch_d;
      fetch_dly_q <= fetch_q;
      load_q      <= load_d;
      tx_q        <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    dir_d    = dir_q;
    mod_d    = mod_q;
    ioc_d    = ioc_q;
    data_d   = data_q;
    cs_vec_d = cs_vec_q;
    fetch_d  = 1'b0;
    load_d   = 1'b0;
    tx_d     = tx_q;

    if (cs_rise) begin
      state_d  = StIdle;
      cnt_d    = 4'd0;
      cs_vec_d = 4'd0;
      tx_d     = 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d    = 4'd0;
          cs_vec_d = 4'd0;
          tx_d     = 8'd0;
          if (cs_fall && armed_q) state_d = StCmd;
        end
        StCmd: begin
          if (sck_rise) begin
            shift_d = new_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              dir_d    = new_byte[7];
              mod_d    = new_byte[6:5];
              ioc_d    = new_byte[4:0];
              cs_vec_d = 4'b0001 << new_byte[6:5];
              fetch_d  = ~new_byte[7];
              state_d  = StData;
            end
          end
        end
        StData: begin
          // First data bit must stay on MISO until the 9th rising edge, so
          // shifting starts only on falls after that edge.
          if (fetch_dly_q) begin
            tx_d = rd_byte;
          end else if (sck_fall && (cnt_q > 4'd8)) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
          if (sck_rise) begin
            shift_d = new_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d = StDone;
              if (dir_q) begin
                data_d = new_byte;
                load_d = 1'b1;
              end
            end
          end
        end
        StDone: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign o_spi_miso  = tx_q[7];
  assign o_ioc       = ioc_q;
  assign o_data_in   = data_q;
  assign o_cs_vec    = cs_vec_q;
  assign o_fetch_cmd = fetch_q;
  assign o_load_cmd  = load_q;

endmodule

// File: tb/tb_spi_cmd_if.sv
// Self-checking bench for spi_cmd_if: directed and random SPI frames scored
// against a frame-level model of expected strobes, select and MISO bytes.
module tb_spi_cmd_if;

  logic        i_sys_clk = 1'b0;
  logic        i_rst_b;
  logic        i_spi_sck;
  logic        i_spi_mosi;
  logic        i_spi_cs_n;
  logic        o_spi_miso;
  logic [4:0]  o_ioc;
  logic [7:0]  o_data_in;
  logic [3:0]  o_cs_vec;
  logic        o_fetch_cmd;
  logic        o_load_cmd;
  logic [31:0] i_rd_data = 32'd0;

  spi_cmd_if dut (
    .i_sys_clk  (i_sys_clk),
    .i_rst_b    (i_rst_b),
    .i_spi_sck  (i_spi_sck),
    .i_spi_mosi (i_spi_mosi),
    .i_spi_cs_n (i_spi_cs_n),
    .o_spi_miso (o_spi_miso),
    .o_ioc      (o_ioc),
    .o_data_in  (o_data_in),
    .o_cs_vec   (o_cs_vec),
    .o_fetch_cmd(o_fetch_cmd),
    .o_load_cmd (o_load_cmd),
    .i_rd_data  (i_rd_data)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  int checks = 0;
  int errors = 0;

  // Module model: read data is valid only in the cycle after the fetch strobe.
  logic [31:0] rd_mem = 32'd0;
  always @(posedge i_sys_clk) i_rd_data <= o_fetch_cmd ? rd_mem : $urandom;

  int         fetch_cnt = 0;
  int         load_cnt = 0;
  int         viol_cnt = 0;
  logic [3:0] strobe_cs = 4'd0;
  logic [4:0] strobe_ioc = 5'd0;
  logic [7:0] load_data = 8'd0;
  logic       fetch_prev = 1'b0;
  logic       load_prev = 1'b0;
  logic [3:0] cs_last = 4'd0;
  logic [3:0] cs_hist[$];
  logic [19:0] rst_snap = 20'hfffff;

  always @(negedge i_sys_clk) begin
    if (o_fetch_cmd) begin
      fetch_cnt++;
      strobe_cs  = o_cs_vec;
      strobe_ioc = o_ioc;
    end
    if (o_load_cmd) begin
      load_cnt++;
      strobe_cs  = o_cs_vec;
      strobe_ioc = o_ioc;
      load_data  = o_data_in;
    end
    if ((o_fetch_cmd && o_load_cmd) || ((o_fetch_cmd || o_load_cmd) && o_cs_vec == 4'd0) ||
        (o_fetch_cmd && fetch_prev) || (o_load_cmd && load_prev))
      viol_cnt++;
    fetch_prev = o_fetch_cmd;
    load_prev  = o_load_cmd;
    if (o_cs_vec !== cs_last) begin
      cs_hist.push_back(o_cs_vec);
      cs_last = o_cs_vec;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // SPI master, mode 0, sck = sys/16; MISO sampled just before each rising edge.
  task automatic spi_xfer(input logic [23:0] tx, input int nbits, input int rst_bit,
                          input int gap, output logic [23:0] rx);
    rx = 24'd0;
    i_spi_cs_n = 1'b0;
    repeat (8) @(negedge i_sys_clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        i_rst_b = 1'b0;
        #2;
        rst_snap = {o_spi_miso, o_ioc, o_data_in, o_cs_vec, o_fetch_cmd, o_load_cmd};
        @(negedge i_sys_clk);
        i_rst_b = 1'b1;
      end
      i_spi_mosi = tx[23-i];
      repeat (8) @(negedge i_sys_clk);
      rx[23-i] = o_spi_miso;
      i_spi_sck = 1'b1;
      repeat (8) @(negedge i_sys_clk);
      i_spi_sck = 1'b0;
    end
    repeat (8) @(negedge i_sys_clk);
    i_spi_cs_n = 1'b1;
    i_spi_mosi = 1'b0;
    repeat (gap) @(negedge i_sys_clk);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] cmd, input logic [7:0] dat,
                          input logic [7:0] extra, input int nbits, input int rst_bit,
                          input int gap, input logic [31:0] rdw);
    logic [23:0] rx;
    logic [7:0]  exp_rd;
    logic        dir;
    int          f0, l0;
    f0     = fetch_cnt;
    l0     = load_cnt;
    rd_mem = rdw;
    dir    = cmd[7];
    exp_rd = rdw[{cmd[6:5], 3'b000} +: 8];
    spi_xfer({cmd, dat, extra}, nbits, rst_bit, gap, rx);
    if (rst_bit >= 0) begin
      check({tag, " reset outputs"}, {12'd0, rst_snap}, 32'd0);
      check({tag, " fetch count"}, fetch_cnt - f0, 1);
      check({tag, " load count"}, load_cnt - l0, 0);
      check({tag, " ioc after"}, {27'd0, o_ioc}, 32'd0);
    end else if (nbits < 16) begin
      check({tag, " fetch count"}, fetch_cnt - f0, 0);
      check({tag, " load count"}, load_cnt - l0, 0);
    end else begin
      check({tag, " fetch count"}, fetch_cnt - f0, dir ? 0 : 1);
      check({tag, " load count"}, load_cnt - l0, dir ? 1 : 0);
      check({tag, " cs_vec at strobe"}, {28'd0, strobe_cs}, 32'd1 << cmd[6:5]);
      check({tag, " ioc at strobe"}, {27'd0, strobe_ioc}, {27'd0, cmd[4:0]});
      check({tag, " miso cmd byte"}, {24'd0, rx[23:16]}, 32'd0);
      if (dir) begin
        check({tag, " load data"}, {24'd0, load_data}, {24'd0, dat});
        check({tag, " miso write"}, {8'd0, rx}, 32'd0);
      end else begin
        check({tag, " miso data"}, {24'd0, rx[15:8]}, {24'd0, exp_rd});
        if (nbits > 16) check({tag, " miso hold"}, {24'd0, rx[7:0]}, {24'd0, {8{exp_rd[0]}}});
      end
    end
    check({tag, " cs_vec idle"}, {28'd0, o_cs_vec}, 32'd0);
    check({tag, " miso idle"}, {31'd0, o_spi_miso}, 32'd0);
  endtask

  initial begin
    int idx;
    logic [3:0] h;
    logic [3:0] exp_h[4];
    i_rst_b    = 1'b0;
    i_spi_sck  = 1'b0;
    i_spi_mosi = 1'b0;
    i_spi_cs_n = 1'b1;
    repeat (3) @(negedge i_sys_clk);
    check("reset outputs", {12'd0, o_spi_miso, o_ioc, o_data_in, o_cs_vec, o_fetch_cmd,
          o_load_cmd}, 32'd0);
    i_rst_b = 1'b1;
    repeat (6) @(negedge i_sys_clk);

    do_frame("write m0", 8'h84, 8'h5A, 8'h00, 16, -1, 8, $urandom);
    do_frame("read m2", 8'h43, 8'h00, 8'h00, 16, -1, 8, {8'h11, 8'hC3, 8'h22, 8'h33});
    do_frame("abort", 8'hA7, 8'hF0, 8'h00, 11, -1, 8, $urandom);
    do_frame("after abort", 8'hA7, 8'hF0, 8'h00, 16, -1, 8, $urandom);
    do_frame("overlong", 8'hE1, 8'h77, 8'hFF, 24, -1, 8, $urandom);
    do_frame("overlong read", 8'h6C, 8'h00, 8'h00, 24, -1, 8, $urandom);
    // After reset, remaining bits would decode as a command if the frame were not ignored.
    do_frame("reset mid read", 8'h43, 8'h55, 8'hAA, 24, 10, 8, $urandom);
    do_frame("after reset", 8'hC9, 8'h3E, 8'h00, 16, -1, 8, $urandom);

    idx = cs_hist.size();
    do_frame("b2b m1", 8'h2A, 8'h00, 8'h00, 16, -1, 4, $urandom);
    do_frame("b2b m3", 8'hE5, 8'h3C, 8'h00, 16, -1, 4, $urandom);
    exp_h = '{4'b0010, 4'b0000, 4'b1000, 4'b0000};
    for (int k = 0; k < 4; k++) begin
      h = (idx + k < cs_hist.size()) ? cs_hist[idx+k] : 4'hx;
      check($sformatf("b2b cs_vec seq %0d", k), {28'd0, h}, {28'd0, exp_h[k]});
    end

    for (int n = 0; n < 20; n++)
      do_frame($sformatf("random %0d", n), 8'($urandom), 8'($urandom), 8'd0, 16, -1,
               $urandom_range(4, 12), $urandom);

    check("strobe rules", viol_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
